hazard_unit: RTL and testbench
==============================

# hazard_unit

Hazard and forwarding controller that sits beside the ID stage of the five-stage MIPS pipeline and drives the stall and forwarding inputs that ID consumes. It keeps a shadow scoreboard of the instructions in E and M (destination register plus Tnew), compares it against the Tuse of the instruction in ID, and decides between three actions: stall ID, forward a ready value into ID, or let ID read the GRF. W-stage forwarding stays inside ID and is out of scope here.

## Interface
Parameters:
- none. Opcode and funct constants and field ranges (`opcode`, `rs`, `rt`, `rd`, `func`, `beq`, `jal`, `jr`, …) come from `const.v`.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ID_instr  in  32  instruction currently in ID.
- E_pc  in  32  PC of the instruction currently in E.
- M_data  in  32  result register of M (ALU result, or PC+8 for jal).
- stall  out  1  freezes IF/ID and inserts a bubble into E.
- ID_rs_sign  out  3  rs forward select: 0 = GRF/W, 1 = from E, 2 = from M. Codes 3–7 are never driven.
- ID_rt_sign  out  3  rt forward select, same encoding as ID_rs_sign.
- ID_rs_data  out  32  forwarded rs value; 0 when ID_rs_sign=0.
- ID_rt_data  out  32  forwarded rt value; 0 when ID_rt_sign=0.
- perf_stall_cnt  out  32  stall-cycle counter (see Configuration).

## Operation
- **Decode of ID_instr:**
  - Write destination: rd for addu/subu; rt for ori/lui/lw; 31 for jal; 0 for everything else.
  - Tnew at E entry: addu/subu/ori/lui = 1; lw = 2; jal = 0.
  - Tuse: beq rs = 0, rt = 0; jr rs = 0; addu/subu rs = 1, rt = 1; ori/lw/sw rs = 1; sw rt = 2.
  - Operands an instruction does not use have Tuse = 3 (never hazard).
- **Scoreboard:** two slots, E and M, each holding {dst[4:0], tnew[1:0]}.
  - On posedge clk:
    - If stall: E <= {0,0} (bubble). Otherwise E <= {decoded dst, decoded Tnew}.
    - Always: M <= {E.dst, E.tnew==0 ? 0 : E.tnew-1}. The decrement saturates at 0.
- **Per source operand s (rs, rt):**
  - A slot matches if slot.dst == s, s != 0, and Tuse(s) < 3.
  - The youngest matching slot decides (E before M). An older slot is never used when E matches.
  - If the deciding slot has tnew > Tuse(s): that operand requests a stall.
  - Else if the deciding slot has tnew == 0:
    - E slot: sign = 1, data = E_pc + 8 (only jal can reach this).
    - M slot: sign = 2, data = M_data.
  - Else (0 < tnew ≤ Tuse): sign = 0; a later stage forwards the value.
  - No matching slot: sign = 0.
- **stall** = rs stall request OR rt stall request.
  - While stall=1, both signs are still driven from the rules above. ID ignores them.
- Register 0 never matches, so there is no hazard or forward on $0.
- Instructions outside the supported set decode as dst = 0, Tuse = 3. They behave as nop.

## Timing
- stall, signs and data are purely combinational from ID_instr, E_pc, M_data and the slots. They have zero-cycle latency and are valid in the same cycle ID evaluates its branch.
- Slots update only on the rising edge.
- **Reset:**
  - rst asserted clears both slots asynchronously.
  - Outputs take their reset values immediately: stall=0, signs=0, data=0, perf_stall_cnt=0.
  - Reset in the middle of a stall drops stall within the same cycle.
- A lw followed by a dependent ALU op stalls exactly 1 cycle.
- A lw followed by a dependent beq or jr stalls 2 cycles.
- An ALU op followed by a dependent beq stalls 1 cycle.

## Configuration
- **`HAZARD_PERF_EN` defined:**
  - perf_stall_cnt increments on every posedge where stall=1 and rst=0.
  - It wraps from 0xFFFFFFFF to 0.
- **Not defined:** perf_stall_cnt is tied to 0 and no counter flop exists. The port list is identical in both builds.

## Structure
- Add to `const.v`: Tnew/Tuse constants, the 3-bit sign codes (`FWD_NONE`=0, `FWD_E`=1, `FWD_M`=2), and the `ra` index 31.
- One sub-module, `hz_decode`, is combinational. It maps an instruction to {dst, tnew, tuse_rs, tuse_rt}.
- `hazard_unit` holds the slots, the compare/priority logic and the optional counter.

## Test plan
- **lw then dependent addu:** `lw $1,0($0)`, then `addu $2,$1,$1` in ID.
  - Cycle 1: stall=1.
  - Next cycle: stall=0, ID_rs_sign=0, ID_rt_sign=0.
- **lw then dependent beq:** `lw $1`, then `beq $1,$0`.
  - stall=1 for exactly 2 cycles, then 0 with sign=0.
- **jal then jr $31:** `jal` at 0x00003000, then `jr $31`.
  - No stall, ID_rs_sign=1, ID_rs_data=0x00003008.
- **Forward from M:** `ori $3,$0,5`, nop, `beq $3,$3` with M_data=5.
  - stall=0, both signs=2, both data=0x00000005.
- **$0 destination:** `addu $0,$1,$1`, then `beq $0,$0`.
  - stall=0, signs=0.
- **Async reset mid-stall:** rst pulse between clock edges while `lw $1` is in E and a dependent beq is in ID.
  - stall falls without waiting for an edge.
  - After release, no stall occurs until a new producer enters.
  - With `HAZARD_PERF_EN` defined, perf_stall_cnt=0.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared decode constants, slot/decode bundles and operand resolution
// for the ID-side hazard unit.
package hazard_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [1:0] TNEW_JAL = 2'd0;
    localparam logic [1:0] TNEW_ALU = 2'd1;
    localparam logic [1:0] TNEW_LW  = 2'd2;

    localparam logic [1:0] TUSE_0    = 2'd0;
    localparam logic [1:0] TUSE_1    = 2'd1;
    localparam logic [1:0] TUSE_2    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [2:0] FWD_NONE = 3'd0;
    localparam logic [2:0] FWD_E    = 3'd1;
    localparam logic [2:0] FWD_M    = 3'd2;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
    } slot_t;

    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
    } dec_t;

    typedef struct packed {
        logic        req_stall;
        logic [2:0]  sign;
        logic [31:0] data;
    } fwd_t;

    // Youngest matching slot wins; an E hit hides any M hit.
    function automatic fwd_t resolve(
        input logic [4:0]  src,
        input logic [1:0]  tuse,
        input slot_t       e,
        input slot_t       m,
        input logic [31:0] e_pc,
        input logic [31:0] m_data
    );
        fwd_t  r;
        slot_t win;
        logic  live, hit_e, hit_m;
        r     = '{req_stall: 1'b0, sign: FWD_NONE, data: 32'd0};
        live  = (src != 5'd0) && (tuse != TUSE_NONE);
        hit_e = live && (e.dst == src);
        hit_m = live && (m.dst == src);
        win   = hit_e ? e : m;
        if (hit_e || hit_m) begin
            if (win.tnew > tuse) begin
                r.req_stall = 1'b1;
            end else if (win.tnew == 2'd0) begin
                r.sign = hit_e ? FWD_E : FWD_M;
                r.data = hit_e ? (e_pc + 32'd8) : m_data;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hazard_unit_decode.sv
// Combinational instruction classifier: destination register, Tnew
// at E entry and Tuse of each source operand.
module hz_decode
    import hazard_unit_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       is_alu_r;
    logic       is_jr;
    logic       unused_fields;

    assign op = instr_i[31:26];
    assign fn = instr_i[5:0];
    assign rt = instr_i[20:16];
    assign rd = instr_i[15:11];

    assign is_alu_r = (op == OP_RTYPE) &&
                      ((fn == FN_ADDU) || (fn == FN_SUBU));
    assign is_jr    = (op == OP_RTYPE) && (fn == FN_JR);

    assign unused_fields = ^{instr_i[25:21], instr_i[10:6]};

    always_comb begin
        dec_o = '{dst: 5'd0, tnew: 2'd0,
                  tuse_rs: TUSE_NONE, tuse_rt: TUSE_NONE};
        unique case (1'b1)
            is_alu_r: begin
                dec_o.dst     = rd;
                dec_o.tnew    = TNEW_ALU;
                dec_o.tuse_rs = TUSE_1;
                dec_o.tuse_rt = TUSE_1;
            end
            is_jr: begin
                dec_o.tuse_rs = TUSE_0;
            end
            (op == OP_ORI): begin
                dec_o.dst     = rt;
                dec_o.tnew    = TNEW_ALU;
                dec_o.tuse_rs = TUSE_1;
            end
            (op == OP_LUI): begin
                dec_o.dst  = rt;
                dec_o.tnew = TNEW_ALU;
            end
            (op == OP_LW): begin
                dec_o.dst     = rt;
                dec_o.tnew    = TNEW_LW;
                dec_o.tuse_rs = TUSE_1;
            end
            (op == OP_SW): begin
                dec_o.tuse_rs = TUSE_1;
                dec_o.tuse_rt = TUSE_2;
            end
            (op == OP_BEQ): begin
                dec_o.tuse_rs = TUSE_0;
                dec_o.tuse_rt = TUSE_0;
            end
            (op == OP_JAL): begin
                dec_o.dst  = REG_RA;
                dec_o.tnew = TNEW_JAL;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/hazard_unit.sv
// Stall/forward controller beside ID with an E/M shadow scoreboard.
// Optional stall-cycle counter is built when HAZARD_PERF_EN is defined.
module hazard_unit
    import hazard_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ID_instr,
    input  logic [31:0] E_pc,
    input  logic [31:0] M_data,
    output logic        stall,
    output logic [2:0]  ID_rs_sign,
    output logic [2:0]  ID_rt_sign,
    output logic [31:0] ID_rs_data,
    output logic [31:0] ID_rt_data,
    output logic [31:0] perf_stall_cnt
);

    dec_t  dec;
    slot_t e_q, e_d;
    slot_t m_q, m_d;
    fwd_t  rs_fwd;
    fwd_t  rt_fwd;

    hz_decode u_dec (
        .instr_i (ID_instr),
        .dec_o   (dec)
    );

    always_comb begin
        rs_fwd = resolve(ID_instr[25:21], dec.tuse_rs,
                         e_q, m_q, E_pc, M_data);
        rt_fwd = resolve(ID_instr[20:16], dec.tuse_rt,
                         e_q, m_q, E_pc, M_data);
    end

    assign stall      = rs_fwd.req_stall | rt_fwd.req_stall;
    assign ID_rs_sign = rs_fwd.sign;
    assign ID_rt_sign = rt_fwd.sign;
    assign ID_rs_data = rs_fwd.data;
    assign ID_rt_data = rt_fwd.data;

    // A stalled ID instruction leaves a bubble behind in E.
    always_comb begin
        e_d = '{dst: 5'd0, tnew: 2'd0};
        if (!stall) begin
            e_d = '{dst: dec.dst, tnew: dec.tnew};
        end
        m_d.dst  = e_q.dst;
        m_d.tnew = (e_q.tnew == 2'd0) ? 2'd0 : (e_q.tnew - 2'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q <= '0;
            m_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_q, perf_d;

    assign perf_d = stall ? (perf_q + 32'd1) : perf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= 32'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed pipeline scenarios plus
// random instruction streams against a producer-age reference model.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ID_instr;
    logic [31:0] E_pc;
    logic [31:0] M_data;
    logic        stall;
    logic [2:0]  ID_rs_sign;
    logic [2:0]  ID_rt_sign;
    logic [31:0] ID_rs_data;
    logic [31:0] ID_rt_data;
    logic [31:0] perf_stall_cnt;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk            (clk),
        .rst            (rst),
        .ID_instr       (ID_instr),
        .E_pc           (E_pc),
        .M_data         (M_data),
        .stall          (stall),
        .ID_rs_sign     (ID_rs_sign),
        .ID_rt_sign     (ID_rt_sign),
        .ID_rs_data     (ID_rs_data),
        .ID_rt_data     (ID_rt_data),
        .perf_stall_cnt (perf_stall_cnt)
    );

    typedef struct {
        logic        stall;
        logic [2:0]  rs_sign;
        logic [2:0]  rt_sign;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] perf;
    } exp_t;

    // A producer that entered E at cycle 'born'; its value is ready
    // 'tnew' cycles after that.
    typedef struct {
        int dst;
        int tnew;
        int born;
    } prod_t;

    exp_t        exp_q[$];
    prod_t       hist[$];
    int          cyc;
    int unsigned perf_m;
    logic        cur_stall;
    int          checks;
    int          errors;
    event        mon_ev;

    function automatic logic [31:0] rtype(input int fn, input int rs,
                                          input int rt, input int rd);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs,
                                          input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic void spec_info(input logic [31:0] ins,
                                      output int dst, output int tnew,
                                      output int use_rs, output int use_rt);
        int op, fn;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        dst = 0; tnew = 0; use_rs = 3; use_rt = 3;
        if (op == 0 && (fn == 33 || fn == 35)) begin
            dst = int'(ins[15:11]); tnew = 1; use_rs = 1; use_rt = 1;
        end else if (op == 0 && fn == 8) begin
            use_rs = 0;
        end else if (op == 13) begin
            dst = int'(ins[20:16]); tnew = 1; use_rs = 1;
        end else if (op == 15) begin
            dst = int'(ins[20:16]); tnew = 1;
        end else if (op == 35) begin
            dst = int'(ins[20:16]); tnew = 2; use_rs = 1;
        end else if (op == 43) begin
            use_rs = 1; use_rt = 2;
        end else if (op == 4) begin
            use_rs = 0; use_rt = 0;
        end else if (op == 3) begin
            dst = 31; tnew = 0;
        end
    endfunction

    function automatic void operand(input int src, input int tuse,
                                    input logic [31:0] epc,
                                    input logic [31:0] md,
                                    output logic stl,
                                    output logic [2:0] sg,
                                    output logic [31:0] dat);
        int age, left;
        stl = 1'b0; sg = 3'd0; dat = 32'd0;
        if (src == 0 || tuse >= 3) return;
        foreach (hist[i]) begin
            age = cyc - hist[i].born;
            if (age > 1) break;
            if (hist[i].dst == src) begin
                left = (hist[i].tnew > age) ? hist[i].tnew - age : 0;
                if (left > tuse) begin
                    stl = 1'b1;
                end else if (left == 0) begin
                    sg  = (age == 0) ? 3'd1 : 3'd2;
                    dat = (age == 0) ? epc + 32'd8 : md;
                end
                return;
            end
        end
    endfunction

    function automatic exp_t predict(input logic [31:0] ins,
                                     input logic [31:0] epc,
                                     input logic [31:0] md);
        exp_t e;
        int   d, t, ur, ut;
        logic s1, s2;
        spec_info(ins, d, t, ur, ut);
        operand(int'(ins[25:21]), ur, epc, md, s1, e.rs_sign, e.rs_data);
        operand(int'(ins[20:16]), ut, epc, md, s2, e.rt_sign, e.rt_data);
        e.stall = s1 | s2;
`ifdef HAZARD_PERF_EN
        e.perf = perf_m;
`else
        e.perf = 32'd0;
`endif
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     nm, act, want, cyc);
        end
    endtask

    task automatic tick(input logic [31:0] ins);
        int d, t, ur, ut;
        @(posedge clk);
        if (cur_stall) begin
            perf_m++;
        end else begin
            spec_info(ins, d, t, ur, ut);
            hist.push_front('{dst: d, tnew: t, born: cyc + 1});
        end
        cyc++;
        while (hist.size() > 4) void'(hist.pop_back());
        #1;
    endtask

    task automatic cycle(input logic [31:0] ins, input logic [31:0] epc,
                         input logic [31:0] md);
        exp_t e;
        ID_instr = ins; E_pc = epc; M_data = md;
        e = predict(ins, epc, md);
        exp_q.push_back(e);
        cur_stall = e.stall;
        tick(ins);
    endtask

    task automatic model_reset();
        hist.delete();
        perf_m = 0;
    endtask

    task automatic reset_mid(input logic [31:0] ins, input logic [31:0] epc,
                             input logic [31:0] md);
        exp_t e;
        ID_instr = ins; E_pc = epc; M_data = md;
        e = predict(ins, epc, md);
        exp_q.push_back(e);
        @(negedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        e = predict(ins, epc, md);
        exp_q.push_back(e);
        -> mon_ev;
        #1;
        rst = 1'b0;
        cur_stall = e.stall;
        tick(ins);
    endtask

    function automatic int rreg();
        int r;
        r = int'($urandom_range(0, 4));
        return (r == 4) ? 31 : r;
    endfunction

    function automatic logic [31:0] rand_instr();
        int a, b, c, imm;
        a = rreg(); b = rreg(); c = rreg();
        imm = int'($urandom_range(0, 65535));
        case ($urandom_range(0, 10))
            0:       return rtype(33, a, b, c);
            1:       return rtype(35, a, b, c);
            2:       return itype(13, a, b, imm);
            3:       return itype(15, a, b, imm);
            4:       return itype(35, a, b, imm);
            5:       return itype(43, a, b, imm);
            6:       return itype(4, a, b, imm);
            7:       return {6'h03, 26'($urandom)};
            8:       return rtype(8, a, 0, 0);
            9:       return itype(8, a, b, imm);
            default: return 32'h0000_0000;
        endcase
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk or mon_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall", 32'(stall), 32'(e.stall));
                chk("rs_sign", 32'(ID_rs_sign), 32'(e.rs_sign));
                chk("rt_sign", 32'(ID_rt_sign), 32'(e.rt_sign));
                chk("rs_data", ID_rs_data, e.rs_data);
                chk("rt_data", ID_rt_data, e.rt_data);
                chk("perf", perf_stall_cnt, e.perf);
            end
        end
    end

    initial begin
        logic [31:0] lw1, ins;
        exp_t        e;
        checks = 0; errors = 0; cyc = 0; perf_m = 0;
        cur_stall = 1'b0;
        lw1 = itype(35, 0, 1, 0);
        rst = 1'b0;
        ID_instr = lw1; E_pc = 32'h0; M_data = 32'h0;
        #1 rst = 1'b1;
        model_reset();
        #2;
        e = predict(lw1, 32'h0, 32'h0);
        exp_q.push_back(e);
        -> mon_ev;
        #9 rst = 1'b0;
        @(posedge clk);
        #1;

        cycle(lw1, 32'h1000, 32'h11);
        cycle(rtype(33, 1, 1, 2), 32'h1004, 32'h22);
        cycle(rtype(33, 1, 1, 2), 32'h1008, 32'h33);

        cycle(lw1, 32'h2000, 32'h0);
        repeat (3) cycle(itype(4, 1, 0, 4), 32'h2004, 32'h0);

        cycle({6'h03, 26'h0000c00}, 32'h2ffc, 32'h0);
        cycle(rtype(8, 31, 0, 0), 32'h3000, 32'h0);

        cycle(itype(13, 0, 3, 5), 32'h0, 32'h0);
        cycle(32'h0, 32'h0, 32'h0);
        cycle(itype(4, 3, 3, 8), 32'h0, 32'h5);

        cycle(rtype(33, 1, 1, 0), 32'h0, 32'h0);
        cycle(itype(4, 0, 0, 8), 32'h0, 32'h0);

        cycle(lw1, 32'h0, 32'h0);
        reset_mid(itype(4, 1, 0, 4), 32'h0, 32'h0);
        cycle(itype(4, 1, 0, 4), 32'h0, 32'h0);

        ins = rand_instr();
        for (int i = 0; i < 3000; i++) begin
            if (!cur_stall) ins = rand_instr();
            if (i % 1000 == 999 && cur_stall)
                reset_mid(ins, $urandom, $urandom);
            else
                cycle(ins, $urandom, $urandom);
        end

        @(negedge clk);
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
